hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Sequences pipeline hold, bubble and flush for the RV32IM 5-stage pipeline. Sits beside the operand-forwarding logic.
- Handles three hazard types that forwarding cannot resolve:
  - load-use hazards (1-cycle stall),
  - multi-cycle DIV/REM in EX (start/done handshake with the divider),
  - taken-branch/jump flushes.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 32, width of stall_count.
- MDU_TIMEOUT, 64, max cycles in MDU_WAIT before mdu_timeout is flagged and the stall is released.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- IF_ID_rs1  in  5  rs1 of instruction in ID.
- IF_ID_rs2  in  5  rs2 of instruction in ID.
- IF_ID_uses_rs2  in  1  ID instruction reads rs2 (R/S/B type).
- ID_EX_rd  in  5  rd of instruction in EX.
- ID_EX_memRead  in  1  EX instruction is a load.
- ex_is_div  in  1  EX instruction is DIV/DIVU/REM/REMU.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mdu_done  in  1  divider result valid (1-cycle pulse).
- stall_count_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- if_id_flush  out  1  IF/ID becomes NOP.
- id_ex_flush  out  1  ID/EX becomes bubble (control bits zeroed).
- ex_mem_bubble  out  1  EX/MEM captures bubble.
- mdu_start  out  1  1-cycle divider start pulse.
- mdu_timeout  out  1  sticky error flag.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (reset_n=0, async):
  - state=RUN, timeout counter=0, mdu_timeout=0, stall_count=0.
  - Outputs during reset: pc_write=if_id_write=id_ex_write=1; all flush, bubble and mdu_start outputs=0.
- States: RUN, MDU_WAIT. Outputs are combinational from state plus inputs. State, counters and flags are registered.
- load_use = ID_EX_memRead && ID_EX_rd!=0 && (ID_EX_rd==IF_ID_rs1 || (IF_ID_uses_rs2 && ID_EX_rd==IF_ID_rs2)).
- RUN, priority highest first:
  1. ex_is_div:
     - mdu_start=1, pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1.
     - next=MDU_WAIT, timeout counter cleared.
     - ex_branch_taken and load_use are ignored this cycle.
  2. ex_branch_taken:
     - if_id_flush=1, id_ex_flush=1, enables stay 1.
     - load_use is suppressed (the ID instruction is squashed).
  3. load_use:
     - pc_write=0, if_id_write=0, id_ex_flush=1 for exactly this cycle.
     - The next cycle re-evaluates. The load has advanced to MEM, so load_use is false and forwarding covers the operand.
  4. Otherwise all enables are 1 and all flush/bubble outputs are 0.
- MDU_WAIT:
  - Holds pc_write=if_id_write=id_ex_write=0 and ex_mem_bubble=1. mdu_start=0.
  - Branch and load inputs are ignored; EX is frozen.
  - mdu_done=1: this cycle enables=1, ex_mem_bubble=0 (EX/MEM captures the div result). next=RUN.
  - Timeout counter increments each cycle without mdu_done. On reaching MDU_TIMEOUT-1, mdu_timeout is set (sticky until reset), the release is the same as mdu_done, and next=RUN.
  - mdu_done in RUN is ignored. A new div entering EX after release starts a fresh handshake.
- stall_count:
  - +1 every cycle pc_write==0; saturates at 2^CNT_W-1.
  - stall_count_clr has priority over increment and gives 0 next cycle.
- Reset asserted mid-MDU_WAIT returns to RUN immediately. Any mdu_done arriving after reset release is ignored.

Test Plan:
- LW x5 in EX, ID uses rs1=x5 -> exactly 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_count 0->1. Same case with ID_EX_rd=x0 -> no stall.
- Load rd=x7, ID rs2=x7, IF_ID_uses_rs2=0 -> no stall. With uses_rs2=1 -> 1-cycle stall.
- ex_branch_taken and load_use in the same cycle -> if_id_flush=id_ex_flush=1, pc_write=1, stall_count unchanged.
- ex_is_div, mdu_done after 33 cycles -> mdu_start high on cycle 0 only; enables low for 33 cycles, high on the done cycle; stall_count=33; state back to RUN.
- MDU_TIMEOUT=8, mdu_done never asserted -> release after 8 stalled cycles, mdu_timeout=1 and sticky. A later div still handshakes normally.
- reset_n pulsed low during MDU_WAIT -> outputs at reset values, stall_count=0. A late mdu_done causes no effect. CNT_W=4 with 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline hold/bubble/flush sequencing for load-use, multi-cycle divide and
// taken-branch hazards, plus a saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_memRead,
    input  logic             ex_is_div,
    input  logic             ex_branch_taken,
    input  logic             mdu_done,
    input  logic             stall_count_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned TO_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN,
        ST_MDU_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    assign load_use = ID_EX_memRead && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) ||
                       (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state and hazard controls; priority in RUN is div > branch > load-use.
    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        timeout_d     = timeout_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mdu_start     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_is_div) begin
                    mdu_start     = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    to_cnt_d      = '0;
                    state_d       = ST_MDU_WAIT;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                // A timeout releases exactly like a done so the pipeline cannot lock up.
                if (mdu_done || (to_cnt_q == TO_LAST)) begin
                    state_d = ST_RUN;
                    if (!mdu_done) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    to_cnt_d      = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Reset forces the free-running controls to their pass-through values.
        if (!reset_n) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_bubble = 1'b0;
            mdu_start     = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_count_clr) begin
            cnt_d = '0;
        end else if (!pc_write && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign mdu_timeout = timeout_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Vector table plus hand sequences for hazard_stall_controller, checked through
// a queue of expected outputs; a second instance covers small CNT_W/MDU_TIMEOUT.
module tb_hazard_stall_controller;

    // Expected output bits: {pc, ifid_wr, idex_wr, ifid_fl, idex_fl, bubble, start, timeout}
    localparam logic [7:0] E_RUN  = 8'b111_00000;
    localparam logic [7:0] E_LU   = 8'b001_01000;
    localparam logic [7:0] E_BR   = 8'b111_11000;
    localparam logic [7:0] E_DIV  = 8'b000_00110;
    localparam logic [7:0] E_WAIT = 8'b000_00100;

    typedef struct {
        string      nm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic [4:0] rd;
        logic       mr;
        logic       div;
        logic       br;
        logic       done;
        logic       clr;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        string       nm;
        logic [7:0]  o;
        logic [31:0] c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_b, rst_s;
    logic [4:0] rs1, rs2, rd;
    logic       uses, mr, div, br, done, clr;

    logic        pcw_b, ifw_b, idw_b, iff_b, idf_b, bub_b, st_b, to_b;
    logic [31:0] cnt_b;
    logic        pcw_s, ifw_s, idw_s, iff_s, idf_s, bub_s, st_s, to_s;
    logic [3:0]  cnt_s;
    logic [7:0]  o_b, o_s;

    assign o_b = {pcw_b, ifw_b, idw_b, iff_b, idf_b, bub_b, st_b, to_b};
    assign o_s = {pcw_s, ifw_s, idw_s, iff_s, idf_s, bub_s, st_s, to_s};

    hazard_stall_controller dut_b (
        .clk(clk), .reset_n(rst_b),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_uses_rs2(uses),
        .ID_EX_rd(rd), .ID_EX_memRead(mr), .ex_is_div(div),
        .ex_branch_taken(br), .mdu_done(done), .stall_count_clr(clr),
        .pc_write(pcw_b), .if_id_write(ifw_b), .id_ex_write(idw_b),
        .if_id_flush(iff_b), .id_ex_flush(idf_b), .ex_mem_bubble(bub_b),
        .mdu_start(st_b), .mdu_timeout(to_b), .stall_count(cnt_b)
    );

    hazard_stall_controller #(.CNT_W(4), .MDU_TIMEOUT(8)) dut_s (
        .clk(clk), .reset_n(rst_s),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_uses_rs2(uses),
        .ID_EX_rd(rd), .ID_EX_memRead(mr), .ex_is_div(div),
        .ex_branch_taken(br), .mdu_done(done), .stall_count_clr(clr),
        .pc_write(pcw_s), .if_id_write(ifw_s), .id_ex_write(idw_s),
        .if_id_flush(iff_s), .id_ex_flush(idf_s), .ex_mem_bubble(bub_s),
        .mdu_start(st_s), .mdu_timeout(to_s), .stall_count(cnt_s)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mcnt_b = 32'd0;
    logic [31:0] mcnt_s = 32'd0;
    exp_t        sbq[$];
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [4:0] a, input logic [4:0] b,
                                input logic u, input logic [4:0] d, input logic m,
                                input logic dv, input logic bt, input logic dn,
                                input logic cl, input logic [7:0] e);
        vec_t v;
        v.nm = nm; v.rs1 = a; v.rs2 = b; v.uses = u; v.rd = d; v.mr = m;
        v.div = dv; v.br = bt; v.done = dn; v.clr = cl; v.exp = e;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, compare at the falling edge.
    task automatic step(input vec_t v, input bit sm);
        exp_t e;
        rs1 = v.rs1; rs2 = v.rs2; uses = v.uses; rd = v.rd; mr = v.mr;
        div = v.div; br = v.br; done = v.done; clr = v.clr;
        e.nm = v.nm; e.o = v.exp; e.c = sm ? mcnt_s : mcnt_b;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk({e.nm, "/out"}, sm ? 32'(o_s) : 32'(o_b), 32'(e.o));
        chk({e.nm, "/cnt"}, sm ? 32'(cnt_s) : cnt_b, e.c);
        if (v.clr) begin
            if (sm) mcnt_s = 32'd0; else mcnt_b = 32'd0;
        end else if (!v.exp[7]) begin
            if (sm) begin
                if (mcnt_s != 32'd15) mcnt_s++;
            end else if (mcnt_b != 32'hFFFF_FFFF) begin
                mcnt_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0; rst_s = 1'b0;
        rs1 = 5'd5; rs2 = 5'd0; uses = 1'b0; rd = 5'd5; mr = 1'b1;
        div = 1'b0; br = 1'b0; done = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        chk("reset/out_b", 32'(o_b), 32'(E_RUN));
        chk("reset/cnt_b", cnt_b, 32'd0);
        chk("reset/out_s", 32'(o_s), 32'(E_RUN));
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        tbl.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("lu_rs1",     5, 0, 0, 5, 1, 0, 0, 0, 0, E_LU));
        tbl.push_back(mk("lu_after",   5, 0, 0, 5, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("lu_x0",      0, 0, 0, 0, 1, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("rs2_nouse",  3, 7, 0, 7, 1, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("rs2_use",    3, 7, 1, 7, 1, 0, 0, 0, 0, E_LU));
        tbl.push_back(mk("rd_nomatch", 3, 4, 1, 9, 1, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("br_and_lu",  5, 0, 0, 5, 1, 0, 1, 0, 0, E_BR));
        tbl.push_back(mk("br_only",    0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR));
        tbl.push_back(mk("done_run",   0, 0, 0, 0, 0, 0, 0, 1, 0, E_RUN));
        tbl.push_back(mk("clr_lu",     6, 0, 0, 6, 1, 0, 0, 0, 1, E_LU));
        tbl.push_back(mk("after_clr",  0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0);

        // Divide completing after 33 stalled cycles; branch/load inputs ignored while waiting.
        step(mk("div_start", 5, 0, 0, 5, 1, 1, 1, 0, 0, E_DIV), 1'b0);
        for (int i = 0; i < 32; i++) step(mk("div_wait", 5, 0, 0, 5, 1, 1, 1, 0, 0, E_WAIT), 1'b0);
        step(mk("div_done", 0, 0, 0, 0, 0, 1, 0, 1, 0, E_RUN), 1'b0);
        chk("div_cnt33", cnt_b, 32'd33);
        step(mk("div_back_run", 5, 0, 0, 5, 1, 0, 0, 0, 0, E_LU), 1'b0);

        // Reset in the middle of a divide wait.
        step(mk("rdiv_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, E_DIV), 1'b0);
        for (int i = 0; i < 3; i++) step(mk("rdiv_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0, E_WAIT), 1'b0);
        rst_b = 1'b0;
        #1;
        chk("rst_mid/out", 32'(o_b), 32'(E_RUN));
        chk("rst_mid/cnt", cnt_b, 32'd0);
        mcnt_b = 32'd0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        step(mk("late_done", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RUN), 1'b0);
        step(mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN), 1'b0);

        // Small instance: timeout release after 8 stalled cycles, sticky flag, saturation.
        rst_s = 1'b1;
        step(mk("to_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, E_DIV), 1'b1);
        for (int i = 0; i < 7; i++) step(mk("to_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0, E_WAIT), 1'b1);
        step(mk("to_release", 0, 0, 0, 0, 0, 1, 0, 0, 0, E_RUN), 1'b1);
        step(mk("to_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN | 8'd1), 1'b1);
        chk("to_cnt8", 32'(cnt_s), 32'd8);
        step(mk("div2_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, E_DIV | 8'd1), 1'b1);
        for (int i = 0; i < 2; i++) step(mk("div2_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0, E_WAIT | 8'd1), 1'b1);
        step(mk("div2_done", 0, 0, 0, 0, 0, 1, 0, 1, 0, E_RUN | 8'd1), 1'b1);
        for (int i = 0; i < 20; i++) step(mk("sat_lu", 8, 0, 0, 8, 1, 0, 0, 0, 0, E_LU | 8'd1), 1'b1);
        step(mk("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN | 8'd1), 1'b1);
        chk("sat_cnt15", 32'(cnt_s), 32'd15);
        step(mk("sat_clr", 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN | 8'd1), 1'b1);
        step(mk("sat_after_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN | 8'd1), 1'b1);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
